// File: rtl/conv_pkg.sv
// Shared widths, controller state type and the output rounding/saturation helper
// for the 3x3 convolution MAC pipeline.
package conv_pkg;

    localparam int unsigned PIX_W  = 16;
    localparam int unsigned KSZ    = 9;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned ACC_W  = 36;

    localparam logic signed [ACC_W-1:0] SAT_HI = 36'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_LO = -36'sd32768;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    // Round half up, arithmetic shift down by frac, clamp to the 16-bit signed range.
    function automatic logic signed [PIX_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc,
                                                          input int unsigned frac);
        logic signed [ACC_W-1:0] rnd;
        logic signed [ACC_W-1:0] shf;
        rnd = (frac > 0) ? (ACC_W'(1) << (frac - 1)) : '0;
        shf = (acc + rnd) >>> frac;
        if (shf > SAT_HI) begin
            return 16'sh7fff;
        end else if (shf < SAT_LO) begin
            return 16'sh8000;
        end else begin
            return shf[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/conv3x3_dot.sv
// Three-stage signed 3x3 dot product: products, adder tree, round/saturate.
// A flush drops every in-flight valid without touching the data registers.
module conv3x3_dot
    import conv_pkg::*;
#(
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [KSZ-1:0][PIX_W-1:0]     win,
    input  logic [KSZ-1:0][PIX_W-1:0]     kern,
    output logic                          out_valid,
    output logic signed [PIX_W-1:0]       out_data,
    output logic                          pending
);

    logic signed [PROD_W-1:0] prod_q [KSZ];
    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  sum_q;
    logic signed [PIX_W-1:0]  res_q;
    logic                     v1_q, v2_q, v3_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < KSZ; i++) begin
            sum_d = sum_d + ACC_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            sum_q <= '0;
            res_q <= '0;
            for (int i = 0; i < KSZ; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            v1_q <= in_valid && !flush;
            v2_q <= v1_q && !flush;
            v3_q <= v2_q && !flush;
            if (in_valid) begin
                for (int i = 0; i < KSZ; i++) begin
                    prod_q[i] <= PROD_W'($signed(win[i])) * PROD_W'($signed(kern[i]));
                end
            end
            if (v1_q) begin
                sum_q <= sum_d;
            end
            if (v2_q) begin
                res_q <= round_sat(sum_q, FRAC_BITS);
            end
        end
    end

    assign out_valid = v3_q;
    assign out_data  = res_q;
    assign pending   = v1_q || v2_q || v3_q;

endmodule

// File: rtl/conv3x3_mac_pipe.sv
// Frame controller for the 3x3 convolution: tracks raster position, qualifies
// complete windows, holds the kernel and feeds the dot-product pipeline.
module conv3x3_mac_pipe
    import conv_pkg::*;
#(
    parameter int unsigned LEN       = 4,
    parameter int unsigned ROWS      = 4,
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_valid,
    input  logic [KSZ-1:0][PIX_W-1:0]     win_in,
    input  logic                          w_wr_en,
    input  logic [3:0]                    w_addr,
    input  logic [PIX_W-1:0]              w_data,
    output logic                          out_valid,
    output logic signed [PIX_W-1:0]       out_data,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          stream_err,
    output logic                          w_err
);

    localparam int unsigned COL_W = $clog2(LEN);
    localparam int unsigned ROW_W = $clog2(ROWS);

    state_e                    state_q, state_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic                      win_vld_q, win_vld_d;
    logic                      accept;
    logic                      flush;
    logic                      pipe_busy;
    logic                      stream_err_q;
    logic                      w_err_q;
    logic [KSZ-1:0][PIX_W-1:0] kern_q;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        win_vld_d  = 1'b0;
        accept     = 1'b0;
        flush      = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pix_valid) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (pix_valid) begin
                    accept = 1'b1;
                end else begin
                    flush   = 1'b1;
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (!win_vld_q && !pipe_busy) begin
                    frame_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Counters hold the position of the pixel about to be accepted.
        if (accept) begin
            win_vld_d = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
            if (col_q == COL_W'(LEN - 1)) begin
                col_d = '0;
                if (row_q == ROW_W'(ROWS - 1)) begin
                    row_d   = '0;
                    state_d = StDrain;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        if (flush) begin
            col_d = '0;
            row_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            col_q        <= '0;
            row_q        <= '0;
            win_vld_q    <= 1'b0;
            stream_err_q <= 1'b0;
            w_err_q      <= 1'b0;
            kern_q       <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_vld_q    <= win_vld_d;
            stream_err_q <= flush;
            w_err_q      <= w_wr_en && ((state_q != StIdle) || (w_addr > 4'd8));
            if (w_wr_en && (state_q == StIdle) && (w_addr < 4'd9)) begin
                kern_q[w_addr] <= w_data;
            end
        end
    end

    conv3x3_dot #(
        .FRAC_BITS(FRAC_BITS)
    ) u_dot (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (win_vld_q),
        .win      (win_in),
        .kern     (kern_q),
        .out_valid(out_valid),
        .out_data (out_data),
        .pending  (pipe_busy)
    );

    assign busy       = (state_q != StIdle);
    assign stream_err = stream_err_q;
    assign w_err      = w_err_q;

endmodule

// File: tb/tb_conv3x3_mac_pipe.sv
// Directed bench for conv3x3_mac_pipe (LEN=ROWS=4, FRAC_BITS=8); the window
// input is built from the stored frame the way the upstream linebuffer would.
module tb_conv3x3_mac_pipe;

    localparam int LEN  = 4;
    localparam int ROWS = 4;
    localparam int NPIX = LEN * ROWS;

    typedef logic [8:0][15:0] win_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    win_t        win_in;
    logic        w_wr_en;
    logic [3:0]  w_addr;
    logic [15:0] w_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        busy;
    logic        frame_done;
    logic        stream_err;
    logic        w_err;

    always #5 clk = ~clk;

    conv3x3_mac_pipe #(
        .LEN      (LEN),
        .ROWS     (ROWS),
        .FRAC_BITS(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .win_in    (win_in),
        .w_wr_en   (w_wr_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .frame_done(frame_done),
        .stream_err(stream_err),
        .w_err     (w_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int outs_v[$];
    int outs_c[$];
    int fd_cnt = 0;
    int fd_cyc = -1;
    int se_cnt = 0;
    int se_cyc = -1;
    int we_cnt = 0;

    always @(negedge clk) begin
        if (out_valid) begin
            outs_v.push_back(int'($signed(out_data)));
            outs_c.push_back(cyc);
        end
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
        if (stream_err) begin
            se_cnt <= se_cnt + 1;
            se_cyc <= cyc;
        end
        if (w_err) we_cnt <= we_cnt + 1;
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [15:0] frame [NPIX];
    int c0;

    function automatic win_t window_of(input int k);
        win_t w;
        int   r;
        int   c;
        w = {9{16'h1234}};
        if (k >= 0) begin
            r = k / LEN;
            c = k % LEN;
            if (r >= 2 && c >= 2) begin
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        w[3*i+j] = frame[(r-2+i)*LEN + (c-2+j)];
                    end
                end
            end
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input logic [3:0] a, input logic [15:0] d);
        w_wr_en = 1'b1;
        w_addr  = a;
        w_data  = d;
        tick();
        w_wr_en = 1'b0;
    endtask

    task automatic load_kernel(input logic [15:0] centre, input logic [15:0] others);
        for (int i = 0; i < 9; i++) begin
            write_w(4'(i), (i == 4) ? centre : others);
        end
        tick();
    endtask

    task automatic fill_frame(input int step, input int base);
        for (int i = 0; i < NPIX; i++) frame[i] = 16'(base + i * step);
    endtask

    // gap/rst_at/wr_at: pixel index at which to drop pix_valid, pulse rst, or
    // attempt a kernel write; -1 disables.
    task automatic run_frame(input int gap, input int rst_at, input int wr_at);
        bit aborted;
        aborted = 1'b0;
        c0 = cyc;
        for (int i = 0; i < NPIX; i++) begin
            win_in = window_of(i - 1);
            if (i == rst_at) begin
                rst = 1'b1;
                pix_valid = 1'b0;
                tick();
                rst = 1'b0;
                check("rst.busy", busy, 0);
                check("rst.out_valid", out_valid, 0);
                check("rst.out_data", out_data, 0);
                check("rst.w_err", w_err, 0);
                aborted = 1'b1;
                break;
            end
            if (i == gap) begin
                pix_valid = 1'b0;
                tick();
                aborted = 1'b1;
                break;
            end
            pix_valid = 1'b1;
            if (i == wr_at) begin
                w_wr_en = 1'b1;
                w_addr  = 4'd4;
                w_data  = 16'h7fff;
            end
            tick();
            w_wr_en = 1'b0;
        end
        pix_valid = 1'b0;
        win_in = aborted ? window_of(-1) : window_of(NPIX - 1);
        tick();
        win_in = window_of(-1);
        repeat (11) tick();
    endtask

    task automatic full_frame(input string tag, input int wr_at,
                              input int e0, input int e1, input int e2, input int e3);
        int nb;
        int fb;
        int exp_v[4];
        int idx[4];
        exp_v = '{e0, e1, e2, e3};
        idx   = '{10, 11, 14, 15};
        nb = outs_v.size();
        fb = fd_cnt;
        run_frame(-1, -1, wr_at);
        check({tag, ".n_out"}, outs_v.size() - nb, 4);
        for (int k = 0; k < 4; k++) begin
            if (nb + k < outs_v.size()) begin
                check({tag, ".data"}, outs_v[nb+k], exp_v[k]);
                check({tag, ".lat"}, outs_c[nb+k] - c0, idx[k] + 4);
            end
        end
        check({tag, ".done_cnt"}, fd_cnt - fb, 1);
        check({tag, ".done_cyc"}, fd_cyc - c0, 20);
        check({tag, ".busy"}, busy, 0);
    endtask

    int nb;
    int fb;
    int sb;
    int wb;

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        w_wr_en   = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        win_in    = window_of(-1);
        tick();
        tick();
        rst = 1'b0;
        check("reset.out_valid", out_valid, 0);
        check("reset.out_data", out_data, 0);
        check("reset.busy", busy, 0);
        check("reset.frame_done", frame_done, 0);
        check("reset.stream_err", stream_err, 0);
        check("reset.w_err", w_err, 0);

        // Centre tap only: output equals the window centre pixel.
        fill_frame(256, 0);
        wb = we_cnt;
        load_kernel(16'd256, 16'd0);
        check("load.no_w_err", we_cnt - wb, 0);
        full_frame("centre", -1, 1280, 1536, 2304, 2560);

        fill_frame(0, 256);
        load_kernel(16'd256, 16'd256);
        full_frame("ones", -1, 2304, 2304, 2304, 2304);

        fill_frame(0, 32767);
        load_kernel(16'h7fff, 16'h7fff);
        full_frame("sat_hi", -1, 32767, 32767, 32767, 32767);
        load_kernel(16'hff00, 16'hff00);
        full_frame("sat_lo", -1, -32768, -32768, -32768, -32768);

        // Gap at pixel 12 with two windows already in the pipeline.
        fill_frame(0, 256);
        load_kernel(16'd256, 16'd256);
        nb = outs_v.size();
        fb = fd_cnt;
        sb = se_cnt;
        run_frame(12, -1, -1);
        check("gap.n_out", outs_v.size() - nb, 0);
        check("gap.done_cnt", fd_cnt - fb, 0);
        check("gap.err_cnt", se_cnt - sb, 1);
        check("gap.err_cyc", se_cyc - c0, 13);
        check("gap.busy", busy, 0);
        full_frame("after_gap", -1, 2304, 2304, 2304, 2304);

        wb = we_cnt;
        full_frame("wr_run", 3, 2304, 2304, 2304, 2304);
        check("wr_run.w_err", we_cnt - wb, 1);
        wb = we_cnt;
        write_w(4'd9, 16'h7fff);
        tick();
        check("bad_addr.w_err", we_cnt - wb, 1);
        full_frame("bad_addr", -1, 2304, 2304, 2304, 2304);

        // Reset mid-frame clears the kernel; reload restores normal results.
        fill_frame(256, 0);
        load_kernel(16'd256, 16'd0);
        nb = outs_v.size();
        fb = fd_cnt;
        run_frame(-1, 7, -1);
        check("rst.n_out", outs_v.size() - nb, 0);
        check("rst.done_cnt", fd_cnt - fb, 0);
        full_frame("kern_cleared", -1, 0, 0, 0, 0);
        load_kernel(16'd256, 16'd0);
        full_frame("reload", -1, 1280, 1536, 2304, 2560);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
